scroll_sequencer: RTL and testbench
===================================

SCROLL_SEQUENCER -- requirements
Module: scroll_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, the number of clock cycles per scroll step (1 s at 50 MHz); legal minimum is 2.
REQ-002 SHALL have parameter NUM_POS, default 5, the number of rotation positions consumed by the downstream 5-to-1 rotation mux.
REQ-003 SHALL have port Clock, input, 1 bit: single clock for the block; all flops are rising-edge.
REQ-004 SHALL have port Resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port Run, input, 1 bit: level; 1 = auto-scroll, 0 = pause.
REQ-006 SHALL have port Dir, input, 1 bit: 0 = increment select, 1 = decrement select.
REQ-007 SHALL have port Step, input, 1 bit: asynchronous pushbutton, active-high; single-step request while paused.
REQ-008 SHALL have port S, output, 3 bits: rotation select to the downstream mux; always in 0..NUM_POS-1.
REQ-009 SHALL have port Tick, output, 1 bit: one-cycle pulse on every advance of S.
REQ-010 SHALL have port Wrap, output, 1 bit: one-cycle pulse when an advance wraps S (4->0 or 0->4).
REQ-011 SHALL have port Running, output, 1 bit: high while the state machine is in RUN; intended for a red LED.

Function
REQ-012 SHALL implement a two-state FSM: PAUSED and RUN.
REQ-013 SHALL go PAUSED->RUN on the first edge where Run=1, and RUN->PAUSED on the first edge where Run=0.
REQ-014 In RUN, SHALL increment the prescaler count each cycle from 0 to TICK_DIV-1, then wrap it to 0.
REQ-015 On the edge where count==TICK_DIV-1 in RUN, SHALL advance S by one position per Dir; Tick (and Wrap, if wrapping) SHALL be high in the same cycle the new S is visible.
REQ-016 Advance rules: with Dir=0, S 4->0 wraps; with Dir=1, S 0->4 wraps; both directions assert Wrap.
REQ-017 In PAUSED, SHALL hold the prescaler count (not clear it), so resuming completes the interrupted period.
REQ-018 A Dir change SHALL take effect at the next advance only, and SHALL NOT disturb the count.
REQ-019 Tick and Wrap SHALL be registered and never high for two consecutive cycles (TICK_DIV>=2).
REQ-020 If S ever holds a value >=NUM_POS, the next edge SHALL force S=0 and SHALL NOT assert Tick or Wrap.
REQ-021 Prescaler width SHALL be $clog2(TICK_DIV) bits.

Reset
REQ-022 While Resetn=0, SHALL asynchronously force S=0, count=0, Tick=0, Wrap=0, Running=0, state=PAUSED, and step-sync/edge flops=0.
REQ-023 Reset asserted mid-period SHALL discard the partial count; on release, the FSM re-enters RUN from count 0 if Run=1.

Configuration
REQ-024 SHALL recognise macro SCROLL_STEP_EN.
REQ-025 When SCROLL_STEP_EN is defined, Step SHALL pass through a 2-flop synchronizer plus a rising-edge detector.
REQ-026 When SCROLL_STEP_EN is defined and the FSM is in PAUSED, a detected edge SHALL advance S once per Dir, with Tick/Wrap, 3 cycles after Step is first sampled high.
REQ-027 When SCROLL_STEP_EN is defined, a detected edge while in RUN, or in the same cycle as a PAUSED->RUN transition, SHALL be discarded.
REQ-028 When SCROLL_STEP_EN is defined, holding Step high SHALL yield exactly one advance.
REQ-029 When SCROLL_STEP_EN is undefined, Step SHALL be ignored, and no synchronizer or edge-detect logic SHALL be present.

Structure
REQ-030 Package scroll_pkg SHALL hold NUM_POS=5, SEL_W=3, and the FSM state enum {PAUSED, RUN}.
REQ-031 The prescaler SHALL be a sub-module tick_gen (ports: Clock, Resetn, en; output term), instantiated once.

Verification (TICK_DIV=4)
REQ-032 Reset release with Run=1, Dir=0 -> S=0,1,2,3,4,0 at cycles 4,8,12,16,20; Wrap high only at cycle 20; Tick high only at those cycles.
REQ-033 Run=1, Dir=1 from S=0 -> first advance S=4 with Wrap=1, then S=3.
REQ-034 Run dropped at count 2, held 10 cycles, then raised -> S advance occurs 2 cycles after resume, not 4.
REQ-035 With SCROLL_STEP_EN, PAUSED, S=2, Step held high 20 cycles -> S=3 exactly 3 cycles after rise, single Tick, no further change; the same stimulus in RUN causes no extra advance.
REQ-036 Resetn pulsed low mid-period at S=3 -> S=0, Tick=0 immediately (asynchronous), Running=0; after release, first advance occurs 4 cycles after Run is seen high.

Source files
------------

// File: rtl/scroll_pkg.sv
// scroll_pkg: shared constants and FSM state type for the scroll sequencer.
//   NUM_POS - rotation positions of the downstream mux
//   SEL_W   - width of the rotation select
//   state_t - sequencer FSM states
package scroll_pkg;
    localparam int NUM_POS = 5;
    localparam int SEL_W = 3;
    typedef enum logic [0:0] {PAUSED = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler that counts 0..TICK_DIV-1 while enabled and holds otherwise.
//   Clock  - rising-edge clock
//   Resetn - asynchronous active-low reset, clears the count
//   en     - count enable; when low the partial period is kept
//   term   - high during the last cycle of a period while enabled
module tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic en,
    output logic term
);
    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] count;

    assign term = en && count == LAST;

    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn)
            count <= '0;
        else if (en)
            count <= term ? '0 : count + W'(1);
endmodule

// File: rtl/scroll_sequencer.sv
// scroll_sequencer: steps a rotation select through 0..NUM_POS-1 once per prescaler period while running.
//   Clock   - rising-edge clock
//   Resetn  - asynchronous active-low reset
//   Run     - 1 = auto-scroll, 0 = pause
//   Dir     - 0 = increment, 1 = decrement
//   Step    - asynchronous pushbutton, single step while paused (only with SCROLL_STEP_EN)
//   S       - rotation select
//   Tick    - one-cycle pulse with every advance of S
//   Wrap    - one-cycle pulse when an advance wraps S
//   Running - high while the FSM is in RUN
// Optional feature macro: SCROLL_STEP_EN enables the Step synchronizer and single-step path.
module scroll_sequencer
    import scroll_pkg::SEL_W, scroll_pkg::state_t, scroll_pkg::PAUSED, scroll_pkg::RUN;
#(
    parameter int TICK_DIV = 50000000,
    parameter int NUM_POS  = scroll_pkg::NUM_POS
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Run,
    input  logic             Dir,
    input  logic             Step,
    output logic [SEL_W-1:0] S,
    output logic             Tick,
    output logic             Wrap,
    output logic             Running
);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_POS - 1);

    state_t state;
    logic   term;
    logic   step_adv;
    logic   advance;
    logic   bad;
    logic   at_end;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .Clock  (Clock),
        .Resetn (Resetn),
        .en     (state == RUN),
        .term   (term)
    );

`ifdef SCROLL_STEP_EN
    // sync[1:0] is the two-flop synchronizer, sync[2] the edge history;
    // the edge is registered so the advance lands 3 cycles after first sampling.
    logic [2:0] sync;
    logic       pulse;

    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) begin
            sync  <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[1:0], Step};
            pulse <= sync[1] & ~sync[2];
        end

    // an edge arriving while running, or as the FSM enters RUN, is dropped
    assign step_adv = pulse && state == PAUSED && !Run;
`else
    logic unused_step;
    assign unused_step = Step;
    assign step_adv    = 1'b0;
`endif

    assign advance = term | step_adv;
    assign bad     = int'(S) >= NUM_POS;
    assign at_end  = Dir ? S == '0 : S == LAST;
    assign Running = state == RUN;

    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) begin
            state <= PAUSED;
            S     <= '0;
            Tick  <= 1'b0;
            Wrap  <= 1'b0;
        end else begin
            state <= Run ? RUN : PAUSED;
            // an out-of-range select is silently recovered to 0 without a pulse
            S     <= bad ? '0 : !advance ? S : at_end ? (Dir ? LAST : '0) : Dir ? S - SEL_W'(1) : S + SEL_W'(1);
            Tick  <= advance && !bad;
            Wrap  <= advance && !bad && at_end;
        end
endmodule

// File: tb/tb_scroll_sequencer.sv
// tb_scroll_sequencer: directed self-checking bench for scroll_sequencer with TICK_DIV=4.
module tb_scroll_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       dir;
    logic       step;
    logic [2:0] s;
    logic       tick;
    logic       wrap;
    logic       running;
    logic       found;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    scroll_sequencer #(.TICK_DIV(4), .NUM_POS(5)) dut (
        .Clock   (clk),
        .Resetn  (rst_n),
        .Run     (run),
        .Dir     (dir),
        .Step    (step),
        .S       (s),
        .Tick    (tick),
        .Wrap    (wrap),
        .Running (running)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int es, input logic et, input logic ew);
        chk({tag, ".s"}, {5'b0, s}, 8'(es));
        chk({tag, ".tick"}, {7'b0, tick}, {7'b0, et});
        chk({tag, ".wrap"}, {7'b0, wrap}, {7'b0, ew});
    endtask

    task automatic expect_run(input string tag, input logic er);
        chk({tag, ".running"}, {7'b0, running}, {7'b0, er});
    endtask

    initial begin
        rst_n = 1'b0;
        run   = 1'b0;
        dir   = 1'b0;
        step  = 1'b0;
        cyc();
        cyc();
        expect_out("reset", 0, 0, 0);
        expect_run("reset", 0);

        // release with Run=1: entry edge, then advances every 4 edges
        run   = 1'b1;
        rst_n = 1'b1;
        cyc();
        expect_run("entry", 1);
        expect_out("entry", 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            cyc();
            expect_out($sformatf("up%0d", i), (i / 4) % 5, i % 4 == 0, i == 20);
        end

        // decrement from 0 wraps to 4, then 3
        dir = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            expect_out($sformatf("dn%0d", i), i < 4 ? 0 : (i < 8 ? 4 : 3), i % 4 == 0, i == 4);
        end

        // pause with count held at 2, resume completes the period in 2 cycles
        dir = 1'b0;
        cyc();
        expect_out("hold0", 3, 0, 0);
        run = 1'b0;
        cyc();
        expect_run("pause", 0);
        expect_out("pause", 3, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            expect_out($sformatf("paused%0d", i), 3, 0, 0);
        end
        run = 1'b1;
        cyc();
        expect_run("resume0", 1);
        expect_out("resume0", 3, 0, 0);
        cyc();
        expect_out("resume1", 3, 0, 0);
        cyc();
        expect_out("resume2", 4, 1, 0);

        // Step held while running adds no advance
        step = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            expect_out($sformatf("runstep%0d", i), (4 + i / 4) % 5, i % 4 == 0, i == 4);
        end
        step = 1'b0;

`ifdef SCROLL_STEP_EN
        run = 1'b0;
        cyc();
        expect_run("spause", 0);
        expect_out("spause", 4, 0, 0);
        step = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            expect_out($sformatf("pstep%0d", i), i >= 4 ? 0 : 4, i == 4, i == 4);
        end
        step = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            expect_out($sformatf("prel%0d", i), 0, 0, 0);
        end
        // edge arriving on the PAUSED->RUN edge is discarded
        step = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            expect_out($sformatf("race%0d", i), 0, 0, 0);
        end
        run = 1'b1;
        cyc();
        expect_run("race.entry", 1);
        expect_out("race.entry", 0, 0, 0);
        run  = 1'b0;
        step = 1'b0;
        cyc();
        expect_run("race.exit", 0);
        expect_out("race.exit", 0, 0, 0);
`else
        run  = 1'b0;
        step = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            expect_out($sformatf("ignored%0d", i), 4, 0, 0);
        end
        step = 1'b0;
`endif

        // asynchronous reset in the middle of a Tick cycle
        run   = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (tick === 1'b1 && s !== 3'd0)
                found = 1'b1;
        end
        chk("tickwait", {7'b0, found}, 8'd1);
        #1 rst_n = 1'b0;
        #1;
        expect_out("async", 0, 0, 0);
        expect_run("async", 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        expect_run("rel0", 1);
        expect_out("rel0", 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            expect_out($sformatf("rel%0d", i), i == 4 ? 1 : 0, i == 4, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
